key_fetch_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single read port of the secure key store among several key consumers, such as the AES engine, the JTAG unlock logic and the access-control masters. The block runs on the SoC clock and sits between the consumers and the key store. It checks each request against a fixed per-requester slot permission mask, fetches the 192-bit key and returns it over a valid/ready response. It scrubs the key holding register as soon as each response completes.

---
 rtl/key_fetch_arbiter.sv | 173 +++++++++++++++++
 tb/tb_key_fetch_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_fetch_arbiter.sv
// key_fetch_arbiter
//   Shares the single read port of the secure key store between NUM_REQ
//   key consumers. One transaction at a time: a round-robin pick in IDLE,
//   a permission check against ALLOW_MASK, one key-store read cycle, and a
//   valid/ready response. The key holding register is scrubbed as soon as
//   each response completes.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   req_valid_i  [NUM_REQ]        per-requester request
//   req_slot_i   [NUM_REQ*SLOT_W] requested slot, requester r at [r*SLOT_W +: SLOT_W]
//   req_ready_o  [NUM_REQ]        one-hot accept pulse (IDLE only)
//   rsp_valid_o  [NUM_REQ]        one-hot response valid
//   rsp_ready_i  [NUM_REQ]        per-requester response accept
//   rsp_key_o    [KEY_W]          key, zero whenever no response is valid
//   rsp_err_o                     response is a denial
//   rom_addr_o   [32]             key store address (zero-extended slot)
//   rom_rdata_i  [KEY_W]          key store read data, combinational
//   deny_cnt_o   [8]              saturating count of denied requests

// Per-requester permission lookup: is this requester's current slot
// both in range and enabled in its row of the allow mask.
module key_fetch_lane #(
  parameter int                    NUM_SLOTS = 5,
  parameter int                    SLOT_W    = 3,
  parameter logic [NUM_SLOTS-1:0]  LANE_MASK = '1
) (
  input  logic [SLOT_W-1:0] slot,
  output logic              allow
);
  // Compare against every legal slot so an out-of-range index simply
  // matches nothing and is denied.
  always_comb begin
    allow = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++)
      if (slot == SLOT_W'(s)) allow = LANE_MASK[s];
  end
endmodule

module key_fetch_arbiter #(
  parameter int                            NUM_REQ    = 3,
  parameter int                            NUM_SLOTS  = 5,
  parameter int                            KEY_W      = 192,
  parameter int                            SLOT_W     = 3,
  parameter logic [NUM_REQ*NUM_SLOTS-1:0]  ALLOW_MASK = '1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*SLOT_W-1:0] req_slot_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [KEY_W-1:0]          rsp_key_o,
  output logic                      rsp_err_o,
  output logic [31:0]               rom_addr_o,
  input  logic [KEY_W-1:0]          rom_rdata_i,
  output logic [7:0]                deny_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  id_q;
  logic [SLOT_W-1:0] slot_q;
  logic [KEY_W-1:0]  key_q;
  logic              err_q;
  logic [7:0]        deny_q;

  logic [NUM_REQ-1:0][SLOT_W-1:0] slot_v;
  logic [NUM_REQ-1:0]             allow_v;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
    assign slot_v[r] = req_slot_i[r*SLOT_W +: SLOT_W];
    key_fetch_lane #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_W    (SLOT_W),
      .LANE_MASK (ALLOW_MASK[r*NUM_SLOTS +: NUM_SLOTS])
    ) u_lane (
      .slot  (slot_v[r]),
      .allow (allow_v[r])
    );
  end

  // Round-robin pick: walk downward so the last hit is the requester
  // closest to ptr, i.e. the highest priority one.
  logic             gnt_any;
  logic [PTR_W-1:0] gnt_id;
  logic [PTR_W-1:0] scan_idx;
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid_i[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  // No accept while reset is asserted, so req_ready_o holds its reset value.
  logic             accept;
  logic [PTR_W-1:0] ptr_nxt;
  assign accept  = (state_q == ST_IDLE) && gnt_any && !rst_i;
  assign ptr_nxt = (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  logic in_resp;
  assign in_resp = (state_q == ST_RESP);

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_out
    assign req_ready_o[r] = accept && (gnt_id == PTR_W'(r));
    assign rsp_valid_o[r] = in_resp && (id_q == PTR_W'(r));
  end

  assign rsp_key_o  = in_resp ? key_q : '0;
  assign rsp_err_o  = in_resp & err_q;
  assign rom_addr_o = (state_q == ST_READ) ? 32'(slot_q) : 32'd0;
  assign deny_cnt_o = deny_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      slot_q  <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
      deny_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            id_q   <= gnt_id;
            slot_q <= slot_v[gnt_id];
            ptr_q  <= ptr_nxt;
            key_q  <= '0;
            if (allow_v[gnt_id]) begin
              err_q   <= 1'b0;
              state_q <= ST_READ;
            end else begin
              // Denied: never touch the key store, respond with err and a zero key.
              err_q   <= 1'b1;
              state_q <= ST_RESP;
              if (deny_q != 8'hFF) deny_q <= deny_q + 8'd1;
            end
          end
        end
        ST_READ: begin
          key_q   <= rom_rdata_i;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's ready completes the response; scrub on completion.
          if (rsp_ready_i[id_q]) begin
            key_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_fetch_arbiter.sv
module tb_key_fetch_arbiter;

  localparam logic [14:0] MASK = 15'h7BFF;  // requester 2 may not read slot 0

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [8:0]   req_slot;
  logic [191:0] rsp_key, rom_rdata;
  logic         rsp_err;
  logic [31:0]  rom_addr;
  logic [7:0]   deny_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [191:0] key_pat(input logic [31:0] s);
    logic [31:0] w;
    w = 32'hC3A50000 + s * 32'h00010001;
    return {6{w}};
  endfunction

  assign rom_rdata = key_pat(rom_addr);

  key_fetch_arbiter #(
    .NUM_REQ(3), .NUM_SLOTS(5), .KEY_W(192), .SLOT_W(3), .ALLOW_MASK(MASK)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_slot_i  (req_slot),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_key_o   (rsp_key),
    .rsp_err_o   (rsp_err),
    .rom_addr_o  (rom_addr),
    .rom_rdata_i (rom_rdata),
    .deny_cnt_o  (deny_cnt)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-timeline model ----------------
  // A transaction is described by its age in cycles since accept:
  // allowed -> age 1 is the key-store read, age >= 2 is the response;
  // denied  -> response from age 1. Idle arbiter grants the first valid
  // requester at or after rr_next.
  bit           m_ok = 0;
  bit           m_act;
  int           m_id, m_age, m_rr, m_deny;
  bit           m_allowed;
  logic [2:0]   m_slot;
  logic [2:0]   e_ready, e_valid;
  logic [191:0] e_key;
  logic         e_err;
  logic [31:0]  e_addr;
  int           pick;

  always @(negedge clk) begin
    if (rst) begin
      m_ok = 1; m_act = 0; m_rr = 0; m_deny = 0;
    end else if (m_ok) begin
      e_ready = '0; e_valid = '0; e_key = '0; e_err = 1'b0; e_addr = '0; pick = -1;
      if (!m_act) begin
        for (int k = 2; k >= 0; k--)
          if (req_valid[(m_rr + k) % 3]) pick = (m_rr + k) % 3;
        if (pick >= 0) e_ready[pick] = 1'b1;
      end else if (m_allowed && m_age == 1) begin
        e_addr = {29'd0, m_slot};
      end else begin
        e_valid[m_id] = 1'b1;
        e_key = m_allowed ? key_pat({29'd0, m_slot}) : '0;
        e_err = !m_allowed;
      end
      chk("m_req_ready", req_ready, e_ready);
      chk("m_rsp_valid", rsp_valid, e_valid);
      chk("m_rsp_key",   rsp_key,   e_key);
      chk("m_rsp_err",   rsp_err,   e_err);
      chk("m_rom_addr",  rom_addr,  e_addr);
      chk("m_deny_cnt",  deny_cnt,  (m_deny > 255) ? 255 : m_deny);
      if (pick >= 0) begin
        m_act     = 1;
        m_id      = pick;
        m_slot    = req_slot[pick*3 +: 3];
        m_allowed = (m_slot < 3'd5) && MASK[pick*5 + int'(m_slot)];
        m_age     = 1;
        m_rr      = (pick + 1) % 3;
        if (!m_allowed) m_deny++;
      end else if (m_act) begin
        if (e_valid != 0 && rsp_ready[m_id]) m_act = 0;
        else m_age++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic samp();
    @(negedge clk); #1;
  endtask
  task automatic do_reset();
    step(); rst = 1; req_valid = '0; rsp_ready = '0;
    step(); rst = 0;
  endtask

  int g_id[$];
  int g_cyc[$];
  int grants;

  initial begin
    rst = 1; req_valid = '0; req_slot = '0; rsp_ready = '0;
    step(); step(); rst = 0;

    // reset state
    samp();
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_valid", rsp_valid, 3'b000);
    chk("rst_key",   rsp_key, 0);
    chk("rst_err",   rsp_err, 0);
    chk("rst_addr",  rom_addr, 0);
    chk("rst_deny",  deny_cnt, 0);

    // single access: requester 1, slot 3
    step(); req_valid = 3'b010; req_slot[3 +: 3] = 3'd3;
    samp(); chk("sa_ready", req_ready, 3'b010);
    step(); req_valid = '0;
    samp(); chk("sa_addr", rom_addr, 3); chk("sa_novalid", rsp_valid, 3'b000);
    step();
    samp(); chk("sa_valid", rsp_valid, 3'b010);
    chk("sa_key", rsp_key, {6{32'hC3A80003}}); chk("sa_err", rsp_err, 0);
    step(); rsp_ready = 3'b010;
    samp(); chk("sa_hs_valid", rsp_valid, 3'b010);
    step(); rsp_ready = '0;
    samp(); chk("sa_key_scrub", rsp_key, 0); chk("sa_done", rsp_valid, 3'b000);

    // fairness: all requesters always valid, responses accepted at once
    do_reset();
    req_valid = 3'b111; rsp_ready = 3'b111;
    req_slot = {3'd4, 3'd2, 3'd1};
    for (int c = 0; c < 18; c++) begin
      samp();
      if (req_ready != 0) begin
        g_id.push_back(req_ready[0] ? 0 : req_ready[1] ? 1 : 2);
        g_cyc.push_back(c);
      end
      step();
    end
    req_valid = '0; rsp_ready = '0;
    chk("fair_count", g_id.size(), 6);
    for (int i = 0; i < 6 && i < g_id.size(); i++) begin
      chk("fair_order", g_id[i], i % 3);
      if (i > 0) chk("fair_space", g_cyc[i] - g_cyc[i-1], 3);
    end

    // denial: requester 2 slot 0 (masked), then slot 7 (out of range)
    req_valid = 3'b100; req_slot[6 +: 3] = 3'd0;
    samp(); chk("dn0_ready", req_ready, 3'b100); chk("dn0_addr", rom_addr, 0);
    step(); req_valid = '0;
    samp(); chk("dn0_valid", rsp_valid, 3'b100); chk("dn0_err", rsp_err, 1);
    chk("dn0_key", rsp_key, 0); chk("dn0_addr2", rom_addr, 0);
    step(); rsp_ready = 3'b100;
    samp();
    step(); rsp_ready = '0; req_valid = 3'b100; req_slot[6 +: 3] = 3'd7;
    samp(); chk("dn7_ready", req_ready, 3'b100);
    step(); req_valid = '0;
    samp(); chk("dn7_valid", rsp_valid, 3'b100); chk("dn7_err", rsp_err, 1);
    chk("dn7_key", rsp_key, 0); chk("dn7_addr", rom_addr, 0);
    step(); rsp_ready = 3'b100;
    samp();
    step(); rsp_ready = '0;
    samp(); chk("dn_cnt", deny_cnt, 2); chk("dn_idle", rsp_valid, 3'b000);

    // backpressure: requester 0 slot 2, requester 1 waits behind it
    step(); req_valid = 3'b011; req_slot[0 +: 3] = 3'd2; req_slot[3 +: 3] = 3'd1;
    samp(); chk("bp_ready", req_ready, 3'b001);
    step(); req_valid = 3'b010;
    samp(); chk("bp_addr", rom_addr, 2); chk("bp_rd_ready", req_ready, 3'b000);
    step();
    for (int i = 0; i < 10; i++) begin
      rsp_ready = (i % 2 == 1) ? 3'b110 : 3'b000;
      samp();
      chk("bp_hold_valid", rsp_valid, 3'b001);
      chk("bp_hold_key", rsp_key, {6{32'hC3A70002}});
      chk("bp_hold_ready", req_ready, 3'b000);
      step();
    end
    rsp_ready = 3'b001;
    samp(); chk("bp_hs_valid", rsp_valid, 3'b001);
    step(); rsp_ready = '0;
    samp(); chk("bp_next_ready", req_ready, 3'b010); chk("bp_scrub", rsp_key, 0);
    step(); req_valid = '0; rsp_ready = 3'b010;
    step(); step(); rsp_ready = '0;

    // reset during READ
    req_valid = 3'b001; req_slot[0 +: 3] = 3'd1;
    samp(); chk("rr_ready", req_ready, 3'b001);
    step(); req_valid = '0; rst = 1;
    step(); rst = 0;
    samp();
    chk("rr_valid", rsp_valid, 0); chk("rr_key", rsp_key, 0); chk("rr_err", rsp_err, 0);
    chk("rr_addr", rom_addr, 0); chk("rr_deny", deny_cnt, 0); chk("rr_ready0", req_ready, 0);
    step(); req_valid = 3'b011;
    samp(); chk("rr_ptr", req_ready, 3'b001);
    step(); req_valid = 3'b010;
    step(); req_valid = '0; rst = 1;   // in RESP
    step(); rst = 0;
    samp();
    chk("rs_valid", rsp_valid, 0); chk("rs_key", rsp_key, 0); chk("rs_err", rsp_err, 0);
    chk("rs_addr", rom_addr, 0);
    step(); req_valid = 3'b011;
    samp(); chk("rs_ptr", req_ready, 3'b001);
    step(); req_valid = '0; rsp_ready = 3'b001;
    step(); step(); rsp_ready = '0;

    // deny counter saturation
    req_valid = 3'b100; req_slot[6 +: 3] = 3'd7; rsp_ready = 3'b100;
    grants = 0;
    for (int c = 0; c < 700 && grants < 260; c++) begin
      samp();
      if (req_ready[2]) grants++;
      step();
    end
    req_valid = '0;
    step(); rsp_ready = '0;
    samp();
    chk("sat_grants", grants, 260);
    chk("sat_cnt", deny_cnt, 255);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
